// File: rtl/alu_pipe_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU pipe arbiter.
// Tag layout travels alongside the datapath: {valid, id, err}.
package alu_pipe_arbiter_pkg;

    localparam int FUNC_W = 8;
    localparam int OPND_W = 4;
    localparam logic [FUNC_W-1:0] FUNC_IDLE = 8'h00;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
        logic    err;
    } tag_t;

    // Legal function codes are exactly one-hot.
    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        return (f != '0) && ((f & (f - FUNC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_pipe_arbiter_rr.sv
// Two-way round-robin arbiter; ptr=0 gives requester 0 priority on contention.
// The pointer always moves away from whichever requester was just granted.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1,
    output logic ptr_nxt
);

    always_comb begin
        gnt0    = valid0 & (~valid1 | ~ptr);
        gnt1    = valid1 & (~valid0 | ptr);
        ptr_nxt = ptr;
        if (gnt0) begin
            ptr_nxt = 1'b1;
        end else if (gnt1) begin
            ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe_arbiter.sv
// Shares the encoder/ALU/parity datapath between two requesters and routes
// each parity result back to its issuer via a tag line matched to the latency.
module alu_pipe_arbiter
    import alu_pipe_arbiter_pkg::*;
#(
    parameter int DP_LATENCY = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic              rsp_parity,
    output logic              rsp_err,
    output logic [FUNC_W-1:0] dp_func,
    output logic [OPND_W-1:0] dp_a,
    output logic [OPND_W-1:0] dp_b,
    input  logic              dp_result,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              busy
);

    logic              ptr, ptr_nxt;
    logic              gnt0, gnt1, issue, win_legal;
    req_id_e           win_id;
    logic [FUNC_W-1:0] win_func;
    logic [OPND_W-1:0] win_a, win_b;
    tag_t              line [DP_LATENCY+1];
    tag_t              last;

    rr_arbiter2 u_arb (
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .ptr     (ptr),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .ptr_nxt (ptr_nxt)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign last       = line[DP_LATENCY];

    always_comb begin
        issue     = gnt0 | gnt1;
        win_id    = gnt1 ? REQ1 : REQ0;
        win_func  = gnt1 ? req1_func : req0_func;
        win_a     = gnt1 ? req1_a : req0_a;
        win_b     = gnt1 ? req1_b : req0_b;
        win_legal = func_legal(win_func);
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= DP_LATENCY; i++) begin
            busy = busy | line[i].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            dp_func    <= FUNC_IDLE;
            dp_a       <= '0;
            dp_b       <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_parity <= 1'b0;
            rsp_err    <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
            for (int i = 0; i <= DP_LATENCY; i++) begin
                line[i] <= '0;
            end
        end else begin
            ptr <= ptr_nxt;
            // Illegal codes still occupy a slot so the response order is kept.
            if (issue) begin
                dp_func <= win_legal ? win_func : FUNC_IDLE;
                dp_a    <= win_legal ? win_a : '0;
                dp_b    <= win_legal ? win_b : '0;
                line[0] <= tag_t'{valid: 1'b1, id: win_id, err: ~win_legal};
            end else begin
                dp_func <= FUNC_IDLE;
                line[0] <= '0;
            end
            for (int i = 1; i <= DP_LATENCY; i++) begin
                line[i] <= line[i-1];
            end
            rsp0_valid <= last.valid & (last.id == REQ0);
            rsp1_valid <= last.valid & (last.id == REQ1);
            rsp_err    <= last.valid & last.err;
            rsp_parity <= last.valid & ~last.err & dp_result;
            cnt0       <= cnt0 + CNT_W'(gnt0);
            cnt1       <= cnt1 + CNT_W'(gnt1);
        end
    end

endmodule

// File: tb/tb_alu_pipe_arbiter.sv
// Scoreboard bench for alu_pipe_arbiter with a two-stage parity datapath stub.
module tb_alu_pipe_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_func = '0, req1_func = '0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_parity, rsp_err;
    logic [7:0] dp_func;
    logic [3:0] dp_a, dp_b;
    logic       dp_result;
    logic [7:0] cnt0, cnt1;
    logic       busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int id;
        bit par;
        bit err;
    } exp_t;
    exp_t exp_q[$];
    int   gnt_q[$];

    alu_pipe_arbiter #(.DP_LATENCY(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_parity(rsp_parity),
        .rsp_err(rsp_err), .dp_func(dp_func), .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result), .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
    );

    always #5 clk = ~clk;

    logic s1, s2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= ^{dp_a, dp_b};
            s2 <= s1;
        end
    end
    assign dp_result = s2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rsp0_valid || rsp1_valid)) begin
            exp_t e;
            checks++;
            if (rsp0_valid && rsp1_valid) begin
                failures++;
                $display("FAIL rsp_both: got rsp0=1 rsp1=1 expected one-hot");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got rsp%0d_valid expected none", rsp1_valid ? 1 : 0);
            end else begin
                e = exp_q.pop_front();
                if ((rsp1_valid ? 1 : 0) != e.id || rsp_parity !== e.par || rsp_err !== e.err) begin
                    failures++;
                    $display("FAIL rsp_data: got id=%0d par=%0b err=%0b expected id=%0d par=%0b err=%0b",
                             rsp1_valid ? 1 : 0, rsp_parity, rsp_err, e.id, e.par, e.err);
                end
            end
        end
    end

    task automatic drive(input int n, input logic [7:0] f, input logic [3:0] a, input logic [3:0] b,
                         input bit keep, output int waits);
        bit   legal;
        bit   ok;
        exp_t e;
        legal = ($countones(f) == 1);
        if (n == 0) begin
            req0_valid = 1'b1; req0_func = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_func = f; req1_a = a; req1_b = b;
        end
        waits = 0;
        ok = 0;
        while (!ok) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                ok = 1;
            end else begin
                waits++;
                if (waits > 100) begin
                    checks++;
                    failures++;
                    $display("FAIL ready_timeout: got no ready on req%0d expected grant", n);
                    break;
                end
            end
        end
        if (ok) begin
            e.id = n;
            e.err = !legal;
            e.par = legal ? ^{a, b} : 1'b0;
            exp_q.push_back(e);
            gnt_q.push_back(n);
            @(posedge clk);
            #1;
            chk("dp_func", dp_func, legal ? f : 8'h00);
            chk("dp_ab", {dp_a, dp_b}, legal ? {a, b} : 8'h00);
        end
        if (!keep) begin
            if (n == 0) req0_valid = 1'b0;
            else        req1_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        gnt_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {rsp0_valid, rsp1_valid, rsp_parity, rsp_err, busy, dp_func, dp_a, dp_b, cnt0, cnt1}, 0);
    endtask

    initial begin
        int w0, w1;
        logic [7:0] f;
        logic [3:0] a, b;
        #3;
        chk_zero("reset_outputs");
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single request with exact latency
        drive(0, 8'b1000_0000, 4'b0101, 4'b1110, 0, w0);
        chk("single_ready_wait", w0, 0);
        chk("single_cnt0", cnt0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("single_early", rsp0_valid, 0);
        @(posedge clk);
        #1;
        chk("single_rsp", {rsp0_valid, rsp1_valid, rsp_parity, rsp_err}, 4'b1010);
        drain();

        // contention: strict alternation
        do_reset();
        fork
            begin
                drive(0, 8'h01, 4'h1, 4'h0, 1, w0);
                drive(0, 8'h04, 4'h3, 4'h5, 1, w0);
                drive(0, 8'h10, 4'h7, 4'h8, 0, w0);
            end
            begin
                drive(1, 8'h02, 4'h2, 4'h2, 1, w1);
                drive(1, 8'h08, 4'hE, 4'h1, 1, w1);
                drive(1, 8'h20, 4'h0, 4'h0, 0, w1);
            end
        join
        chk("cont_ngrants", gnt_q.size(), 6);
        for (int i = 0; i < 6 && i < gnt_q.size(); i++) begin
            chk("cont_order", gnt_q[i], i % 2);
        end
        drain();
        chk("cont_cnt", {cnt0, cnt1}, {8'd3, 8'd3});

        // illegal codes on requester 1
        drive(1, 8'b0000_0000, 4'hF, 4'h1, 0, w1);
        drive(1, 8'b1100_0000, 4'h6, 4'h3, 0, w1);
        drain();
        chk("illegal_cnt1", cnt1, 5);

        // hold stability: req1 waits one cycle behind req0
        do_reset();
        fork
            drive(0, 8'h40, 4'hA, 4'h3, 0, w0);
            drive(1, 8'h80, 4'h9, 4'hC, 0, w1);
        join
        chk("hold_wait0", w0, 0);
        chk("hold_wait1", w1, 1);
        drain();

        // counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            f = 8'(1 << (i % 8));
            a = 4'(i);
            b = 4'(i >> 4);
            drive(0, f, a, b, (i < 255), w0);
            if (i == 127) chk("wrap_mid", cnt0, 128);
        end
        chk("wrap_cnt0", cnt0, 0);
        drain();

        // reset with two ops in flight
        do_reset();
        drive(0, 8'h01, 4'h3, 4'h0, 0, w0);
        drive(1, 8'h02, 4'h1, 4'h1, 0, w1);
        @(posedge clk);
        #2;
        chk("midflight_busy", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_zero("midflight_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midflight_busy_after", busy, 0);
        chk("midflight_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_pipe_arbiter.md
Name: alu_pipe_arbiter

Overview:
- Shares the 2-stage encoder/ALU/parity datapath between two requesters.
- Round-robin arbitration; at most one operation issued per cycle.
- Drives the datapath inputs and carries a valid/tag/error shift line in step with the datapath latency.
- Routes each parity result back to the requester that issued it, and keeps per-requester issue counters.

Parameters:
- DP_LATENCY, 2: cycles from dp_func/dp_a/dp_b sampled at a clk edge to the matching dp_result (datapath has two pipeline registers).
- CNT_W, 8: width of the per-requester issue counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_func  in  8  requester 0 function code (one-hot).
- req0_a  in  4  requester 0 operand A.
- req0_b  in  4  requester 0 operand B.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_func, req1_a, req1_b, req1_ready: same as requester 0.
- rsp0_valid  out  1  one-cycle pulse, result for requester 0.
- rsp1_valid  out  1  one-cycle pulse, result for requester 1.
- rsp_parity  out  1  parity result; valid with either rsp*_valid.
- rsp_err  out  1  illegal function code; valid with either rsp*_valid.
- dp_func  out  8  function code to the datapath.
- dp_a  out  4  operand A to the datapath.
- dp_b  out  4  operand B to the datapath.
- dp_result  in  1  parity output from the datapath.
- cnt0  out  CNT_W  operations issued for requester 0 (wraps).
- cnt1  out  CNT_W  operations issued for requester 1 (wraps).
- busy  out  1  any operation in flight.

Behaviour:
- Reset: asynchronous, active-low on rst_n. Clears the shift line, rsp0_valid, rsp1_valid, rsp_parity, rsp_err, cnt0, cnt1, busy and dp_func/dp_a/dp_b (all zero). Round-robin pointer resets to requester 0 priority.
- Handshake:
  - reqN_ready is combinational: high only when reqN_valid and reqN wins arbitration this cycle.
  - Transfer occurs on a clk edge with valid&ready.
  - Requester holds func/a/b stable while valid and not ready.
  - The datapath never stalls, so there is no response backpressure; the requester must capture its response pulse.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the pointer holder wins.
  - The pointer moves to the other requester after every grant, so strict alternation holds under continuous contention.
- Issue registers (dp_*):
  - Grant with legal func: dp_func/dp_a/dp_b load the winner's func/a/b.
  - Grant with illegal func (zero or more than one bit set): dp_func loads 8'h00, operands load zero, and the tag carries err=1.
  - No grant: dp_func = 8'h00 (idle), operands hold.
- Shift line:
  - DP_LATENCY+1 entries of {valid, id, err}; entry 0 loads on the same edge as dp_*.
  - At the last entry, dp_result is sampled into rsp_parity and the matching rsp*_valid pulses for one cycle.
  - rsp_err copies the err bit; rsp_parity is forced to 0 when err=1.
- Latency: request accepted at edge k → rsp*_valid high in the cycle after edge k+DP_LATENCY+1, i.e. 3 edges for the default.
- Throughput: one issue per cycle; back-to-back responses allowed, with rsp0/rsp1 interleaved in issue order. rsp0_valid and rsp1_valid are never high together.
- Counters:
  - cntN increments on each accepted reqN, including illegal ones.
  - Wraps from 2^CNT_W-1 to 0.
- busy = OR of the valid bits in the shift line.
- Simultaneous events: issue and response in the same cycle are independent.
- Reset mid-operation: in-flight operations are dropped with no response; the datapath output after reset is ignored until new tags arrive.

Decomposition:
- Shared package (include file) holds:
  - FUNC_W = 8, OPND_W = 4, FUNC_IDLE = 8'h00.
  - Requester id encoding: 0, 1.
  - Tag field layout {valid, id, err}.
- Natural sub-module: rr_arbiter2. Takes two valids and the pointer; produces the grant and the next pointer.

Test Plan:
- Bench datapath stub: a DP_LATENCY-cycle delay line returning ^{dp_a, dp_b}.
- Single request: req0 func=8'b10000000, A=0101, B=1110 → req0_ready same cycle; rsp0_valid=1, rsp_parity=1, rsp_err=0 three edges later; cnt0=1.
- Contention: both valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; responses arrive in the same order; cnt0=cnt1=3.
- Illegal code: req1 func=8'b00000000, then func=8'b11000000 → dp_func=8'h00 both times; two rsp1_valid pulses with rsp_err=1, rsp_parity=0.
- Hold stability: req1 held valid while req0 is granted → req1_ready=0 first cycle, 1 next; func/A/B captured unchanged.
- Counter wrap: 256 accepted req0 ops → cnt0 returns to 0 and no response is lost.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 ops in flight → outputs zero immediately; no rsp*_valid after release; busy=0.
